imem_load_ctrl: RTL and testbench

Sequencer and arbiter for the single-port 1024×32 instruction memory. The memory's write enable, address and write data are shared between the CPU fetch path (read-only) and a byte-stream program loader. When a load session starts, the block stalls fetch, assembles incoming bytes into 32-bit words, and writes them to consecutive memory words. When the session ends, the port returns to fetch.

---
 rtl/imem_load_ctrl.sv | 175 +++++++++++++++++
 tb/tb_imem_load_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl.sv
// Instruction-memory port arbiter: CPU fetch in IDLE, byte-stream program loading otherwise.
// Optional load checksum (sum_in/sum_err ports) is enabled by defining IMEM_LOAD_CHECKSUM_EN.
module imem_load_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic [9:0]  load_base,
  input  logic [10:0] load_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [9:0]  fetch_addr,
  output logic [31:0] fetch_data,
  output logic        fetch_stall,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        busy,
  output logic        done,
`ifdef IMEM_LOAD_CHECKSUM_EN
  input  logic [31:0] sum_in,
  output logic        sum_err,
`endif
  output logic [10:0] words_loaded
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSEMBLE = 2'd1,
    ST_WRITE    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  base_q, base_d;
  logic [10:0] count_q, count_d;
  logic [10:0] words_q, words_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [9:0]  wr_addr_s;
  logic [10:0] words_inc_s;

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic [31:0] sum_exp_q, sum_exp_d;
  logic        sum_err_q, sum_err_d;
`endif

  // Write address wraps naturally in 10 bits.
  assign wr_addr_s   = base_q + words_q[9:0];
  assign words_inc_s = words_q + 11'd1;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      base_q    <= 10'd0;
      count_q   <= 11'd0;
      words_q   <= 11'd0;
      word_q    <= 32'd0;
      idx_q     <= 2'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_q     <= 32'd0;
      sum_exp_q <= 32'd0;
      sum_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      words_q   <= words_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_q     <= sum_d;
      sum_exp_q <= sum_exp_d;
      sum_err_q <= sum_err_d;
`endif
    end
  end

  // Next-state, datapath updates and port muxing.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    words_d     = words_q;
    word_d      = word_q;
    idx_d       = idx_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
    sum_d       = sum_q;
    sum_exp_d   = sum_exp_q;
    sum_err_d   = sum_err_q;
`endif
    byte_ready  = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = wr_addr_s;
    fetch_data  = 32'h0000_0000;
    fetch_stall = 1'b1;
    busy        = 1'b1;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mem_addr    = fetch_addr;
        fetch_data  = mem_dout;
        fetch_stall = 1'b0;
        busy        = 1'b0;
        if (load_start) begin
          base_d  = load_base;
          count_d = (load_count > 11'd1024) ? 11'd1024 : load_count;
          words_d = 11'd0;
          idx_d   = 2'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
          sum_d     = 32'd0;
          sum_exp_d = sum_in;
          sum_err_d = 1'b0;
`endif
          if (load_count == 11'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ASSEMBLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ASSEMBLE: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          // Little-endian packing: byte k lands in bits [8k+7:8k].
          word_d[{idx_q, 3'b000} +: 8] = byte_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_ASSEMBLE;
          end
        end else begin
          state_d = ST_ASSEMBLE;
        end
      end
      ST_WRITE: begin
        mem_we  = 1'b1;
        words_d = words_inc_s;
`ifdef IMEM_LOAD_CHECKSUM_EN
        sum_d   = sum_q + word_q;
`endif
        if (words_inc_s == count_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ASSEMBLE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
`ifdef IMEM_LOAD_CHECKSUM_EN
        sum_err_d = (sum_q != sum_exp_q);
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_din      = word_q;
  assign words_loaded = words_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign sum_err      = sum_err_q;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with a behavioural 1024x32 asynchronous-read memory.
module tb_imem_load_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, load_start, byte_valid, byte_ready;
  logic [9:0]  load_base, fetch_addr, mem_addr;
  logic [10:0] load_count, words_loaded;
  logic [7:0]  byte_data;
  logic [31:0] fetch_data, mem_din, mem_dout;
  logic        fetch_stall, mem_we, busy, done;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] sum_in;
  logic        sum_err;
`endif

  int passed = 0;
  int total  = 0;
  logic [7:0]  bq [0:15];
  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  imem_load_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base(load_base),
    .load_count(load_count), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_stall(fetch_stall), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy), .done(done),
`ifdef IMEM_LOAD_CHECKSUM_EN
    .sum_in(sum_in), .sum_err(sum_err),
`endif
    .words_loaded(words_loaded)
  );

  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One load session starting in the current cycle (cycle 0); held-valid mode checks exact timing.
  task automatic run_load(input logic [9:0] base, input logic [10:0] cnt, input bit toggle);
    int  ptr = 0;
    int  nw;
    int  w;
    bit  seen_done = 1'b0;
    bit  exp_rdy;
    bit  wr;
    nw = (cnt > 11'd1024) ? 1024 : int'(cnt);
    load_start = 1'b1; load_base = base; load_count = cnt; byte_valid = 1'b0;
    #1;
    check1("stall_cycle0", fetch_stall, 1'b0);
    step();
    load_start = 1'b0;
    for (int c = 1; c <= 20 * nw + 20 && !seen_done; c++) begin
      byte_valid = (ptr < 4 * nw) && (!toggle || (c % 2 == 1));
      byte_data  = bq[ptr % 16];
      #1;
      if (!toggle) begin
        wr      = (c % 5 == 0) && (c <= 5 * nw);
        exp_rdy = (c % 5 != 0) && (c <= 5 * nw);
        check1("byte_ready", byte_ready, exp_rdy);
        check1("mem_we", mem_we, wr);
        check1("done", done, c == 5 * nw + 1);
        if (wr) begin
          w = c / 5 - 1;
          check32("mem_addr", {22'd0, mem_addr}, {22'd0, 10'(int'(base) + w)});
          check32("mem_din", mem_din, {bq[(4*w+3)%16], bq[(4*w+2)%16], bq[(4*w+1)%16], bq[(4*w)%16]});
        end
      end else begin
        exp_rdy = byte_ready;
      end
      check1("fetch_stall", fetch_stall, 1'b1);
      check1("busy", busy, 1'b1);
      check32("fetch_nop", fetch_data, 32'h0000_0000);
      if (exp_rdy && byte_valid) ptr++;
      if (done) seen_done = 1'b1;
      step();
    end
    check1("done_seen", seen_done, 1'b1);
    byte_valid = 1'b0;
    #1;
    check1("stall_after", fetch_stall, 1'b0);
    check1("busy_after", busy, 1'b0);
    check32("words_loaded", {21'd0, words_loaded}, 32'(nw));
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; load_base = 10'd0; load_count = 11'd0;
    byte_valid = 1'b0; byte_data = 8'd0; fetch_addr = 10'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
    sum_in = 32'd0;
`endif
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
    mem[5]   = 32'h2008_0007;
    mem[101] = 32'hCAFE_F00D;
    step(); step();
    check1("rst_byte_ready", byte_ready, 1'b0);
    check1("rst_stall", fetch_stall, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_we", mem_we, 1'b0);
    check32("rst_words", {21'd0, words_loaded}, 32'd0);

    rst_n = 1'b1; fetch_addr = 10'd5;
    #1;
    check32("fetch_word5", fetch_data, 32'h2008_0007);
    check32("fetch_addr", {22'd0, mem_addr}, 32'd5);
    check1("fetch_we", mem_we, 1'b0);
    step();

    bq[0] = 8'h78; bq[1] = 8'h56; bq[2] = 8'h34; bq[3] = 8'h12;
    bq[4] = 8'hEF; bq[5] = 8'hBE; bq[6] = 8'hAD; bq[7] = 8'hDE;
    for (int i = 8; i < 16; i++) bq[i] = 8'(i);
    run_load(10'd0, 11'd2, 1'b0);
    check32("mem0", mem[0], 32'h1234_5678);
    check32("mem1", mem[1], 32'hDEAD_BEEF);
    fetch_addr = 10'd1;
    #1;
    check32("fetch_after_load", fetch_data, 32'hDEAD_BEEF);
    step();

    for (int i = 0; i < 16; i++) bq[i] = 8'(i + 1);
    run_load(10'd1023, 11'd2, 1'b0);
    check32("mem1023", mem[1023], 32'h0403_0201);
    check32("mem0_wrap", mem[0], 32'h0807_0605);
    step();

    run_load(10'd7, 11'd0, 1'b0);
    step();

    // Abort a 3-word session with reset after six accepted bytes.
    for (int i = 0; i < 16; i++) bq[i] = 8'(8'h10 + i);
    load_start = 1'b1; load_base = 10'd100; load_count = 11'd3;
    step();
    load_start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      byte_valid = 1'b1;
      byte_data  = bq[(c < 5) ? c - 1 : c - 2];
      #1;
      check1("abort_done", done, 1'b0);
      step();
    end
    rst_n = 1'b0;
    step();
    check1("abort_byte_ready", byte_ready, 1'b0);
    check1("abort_stall", fetch_stall, 1'b0);
    check1("abort_busy", busy, 1'b0);
    check1("abort_done_rst", done, 1'b0);
    check1("abort_we", mem_we, 1'b0);
    check32("abort_words", {21'd0, words_loaded}, 32'd0);
    check32("abort_mem100", mem[100], 32'h1312_1110);
    check32("abort_mem101", mem[101], 32'hCAFE_F00D);
    rst_n = 1'b1; byte_valid = 1'b0;
    step();
    check1("abort_no_done", done, 1'b0);

    run_load(10'd200, 11'd2, 1'b1);
    check32("toggle_mem200", mem[200], 32'h1312_1110);
    check32("toggle_mem201", mem[201], 32'h1716_1514);
    step();

    run_load(10'd0, 11'd1500, 1'b0);
    check32("clamp_mem1023", mem[1023], 32'h1F1E_1D1C);
    step();

`ifdef IMEM_LOAD_CHECKSUM_EN
    bq[0] = 8'h01; bq[1] = 8'h00; bq[2] = 8'h00; bq[3] = 8'h00;
    bq[4] = 8'h02; bq[5] = 8'h00; bq[6] = 8'h00; bq[7] = 8'h00;
    sum_in = 32'd3;
    run_load(10'd300, 11'd2, 1'b0);
    check1("sum_ok", sum_err, 1'b0);
    step();
    sum_in = 32'd4;
    run_load(10'd300, 11'd2, 1'b0);
    check1("sum_bad", sum_err, 1'b1);
    step();
    check1("sum_hold", sum_err, 1'b1);
    sum_in = 32'd0; load_start = 1'b1; load_count = 11'd0;
    step();
    load_start = 1'b0;
    check1("sum_cleared", sum_err, 1'b0);
    step(); step();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
